agc_gain_stepper: RTL
=====================

// Module: agc_gain_stepper
// PURPOSE
//  Owns the PGA gain code for the AGC loop and sequences every gain change into the analog front end.
//  Consumes step requests from the AGC controller (adjust / up_dn), saturates the code at the rails,
//  and shifts each new code serially into the PGA register. It then waits a settling window before
//  accepting the next step. Flags gain_done back to the controller when the loop is pinned at a rail.
// PARAMETERS
//  GAIN_W        6   width of PGA gain code
//  GAIN_INIT     32  gain code after reset
//  STEP          1   code increment/decrement per accepted step
//  SETTLE_CYCLES 8   idle cycles after pga_load before ready re-asserts (>=1)
//  RAIL_LIMIT    4   consecutive at-rail requests that assert gain_done (>=1)
// PORTS
//  clk           in   1       system clock
//  RESETn        in   1       asynchronous active-low reset
//  enable        in   1       AGC active; low clears rail tracking
//  step_req      in   1       one-cycle step request (controller adjust)
//  step_up       in   1       direction, valid with step_req: 1=up, 0=down
//  ready         out  1       stepper can accept step_req this cycle
//  gain_code     out  GAIN_W  current committed gain code
//  pga_sclk      out  1       serial clock to PGA register
//  pga_sdata     out  1       serial data, MSB first
//  pga_load      out  1       one-cycle latch strobe after last bit
//  at_max        out  1       gain_code == 2**GAIN_W-1
//  at_min        out  1       gain_code == 0
//  gain_done     out  1       sticky: RAIL_LIMIT consecutive rail hits
//  req_dropped   out  1       sticky: step_req seen while ready=0
// BEHAVIOUR
//  Reset values: state IDLE, gain_code=GAIN_INIT, ready=1, pga_sclk=0, pga_sdata=0, pga_load=0,
//   gain_done=0, req_dropped=0, rail count=0. at_max/at_min are combinational from gain_code.
//  States: IDLE -> SHIFT -> LOAD -> SETTLE -> IDLE. ready=1 only in IDLE.
//  IDLE with enable & step_req:
//   - Not at rail in the requested direction: at the next edge, gain_code <= code +/- STEP,
//     clamped to [0, 2**GAIN_W-1]. Rail count clears. State goes to SHIFT.
//   - Already at rail in the requested direction: no transaction; gain_code is unchanged and
//     ready stays 1. Rail count increments, saturating at RAIL_LIMIT. gain_done sets at the edge
//     where the count reaches RAIL_LIMIT.
//  IDLE with step_req & !enable: ignored and not counted as dropped.
//  SHIFT: 2*GAIN_W cycles. For each bit, the MSB-first bit is driven on pga_sdata with
//   pga_sclk=0 for one cycle, then pga_sclk=1 for one cycle with pga_sdata held.
//  LOAD: one cycle with pga_load=1, pga_sclk=0.
//  SETTLE: SETTLE_CYCLES cycles, then IDLE.
//  Latency: the accept edge is followed by 2*GAIN_W+1+SETTLE_CYCLES cycles with ready=0.
//  step_req while ready=0 is dropped and sets req_dropped. It is never queued.
//  enable falling mid-transaction: the transaction completes so the PGA never sees a partial word.
//   Then the block idles.
//  enable low (any state): rail count and gain_done clear. gain_code holds.
//  req_dropped clears only on reset.
//  Async reset mid-SHIFT: outputs return to reset values at once. No pga_load is issued.
//  STEP larger than headroom: clamp to the rail. This counts as a real step and a transaction runs.
// STRUCTURE
//  agc_pkg: state enum (IDLE/SHIFT/LOAD/SETTLE), and a function for the saturating add/sub.
//  Sub-module agc_pga_shifter: handles the GAIN_W parallel load, bit/phase counter, sclk/sdata/load
//   generation, and busy/done. Top level keeps the FSM, code register, settle counter and rail logic.
// TESTING (GAIN_W=6, GAIN_INIT=32, STEP=1, SETTLE_CYCLES=8, RAIL_LIMIT=4)
//  1. Reset, then pulse step_req with step_up=1 -> gain_code=33 at the next edge. pga_sdata shows
//     100001 MSB first over 6 sclk rising edges, then pga_load pulses once. ready is low for 21 cycles.
//  2. Step down from 1, then step down again -> first step gives code 0 with a transaction and
//     at_min=1. Second step runs no transaction, ready stays 1 and rail count=1.
//  3. At code 63, issue 4 spaced step_up requests -> no sclk activity. gain_done rises on the
//     4th accept edge and stays high. One step_down then gives 62, rail count 0, gain_done held.
//  4. step_req 3 cycles into SHIFT -> request ignored, req_dropped=1. The shifted word is unchanged.
//  5. Drop enable mid-SHIFT -> the full word and pga_load still complete. gain_done clears.
//     A step_req issued with enable low is ignored.
//  6. Assert RESETn low mid-SHIFT, off a clock edge -> all outputs immediately at reset values.
//     gain_code=32 and no pga_load pulse.

Source files
------------

// File: rtl/agc_pkg.sv
// rtl/agc_pkg.sv - shared state encoding and saturating step helper for the AGC gain stepper
package agc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_LOAD   = 2'd2,
      ST_SETTLE = 2'd3
   } agc_state_e;

   // Move code by step toward the requested rail, clamping at 0 and max_code.
   function automatic int sat_step(input int code, input logic up, input int step,
                                   input int max_code);
      int result;
      if (up) begin
         result = (step >= max_code - code) ? max_code : code + step;
      end else begin
         result = (step >= code) ? 0 : code - step;
      end
      return result;
   endfunction

endpackage

// File: rtl/agc_pga_shifter.sv
// rtl/agc_pga_shifter.sv - MSB-first serial load of the PGA gain register with latch strobe
module agc_pga_shifter
#(
   parameter int GAIN_W = 6
) (
   input  logic              clk,
   input  logic              RESETn,
   input  logic              start,
   input  logic [GAIN_W-1:0] data,
   output logic              busy,
   output logic              shift_last,
   output logic              done,
   output logic              pga_sclk,
   output logic              pga_sdata,
   output logic              pga_load
);

   localparam int PHASES = 2 * GAIN_W;
   localparam int CW     = $clog2(PHASES);

   logic [GAIN_W-1:0] shreg;
   logic [CW-1:0]     phase;
   logic              active;
   logic              load_r;

   // Walk 2*GAIN_W phases; phase[0] is the sclk level and the word advances after each high phase.
   always_ff @(posedge clk or negedge RESETn) begin
      if (!RESETn) begin
         shreg  <= '0;
         phase  <= '0;
         active <= 1'b0;
         load_r <= 1'b0;
      end else begin
         load_r <= 1'b0;
         if (start) begin
            shreg  <= data;
            phase  <= '0;
            active <= 1'b1;
         end else if (active) begin
            if (phase[0]) begin
               shreg <= {shreg[GAIN_W-2:0], 1'b0};
            end
            if (phase == CW'(PHASES - 1)) begin
               phase  <= '0;
               active <= 1'b0;
               load_r <= 1'b1;
            end else begin
               phase <= phase + 1'b1;
            end
         end
      end
   end

   // Serial pins are gated by active so an idle or reset shifter drives all zeros.
   always_comb begin
      shift_last = active && (phase == CW'(PHASES - 1));
      busy       = active | load_r;
      done       = load_r;
      pga_sclk   = active & phase[0];
      pga_sdata  = active & shreg[GAIN_W-1];
      pga_load   = load_r;
   end

endmodule

// File: rtl/agc_gain_stepper.sv
// rtl/agc_gain_stepper.sv - PGA gain code owner: step saturation, PGA update sequencing, rail detection
module agc_gain_stepper
   import agc_pkg::*;
#(
   parameter int GAIN_W        = 6,
   parameter int GAIN_INIT     = 32,
   parameter int STEP          = 1,
   parameter int SETTLE_CYCLES = 8,
   parameter int RAIL_LIMIT    = 4
) (
   input  logic              clk,
   input  logic              RESETn,
   input  logic              enable,
   input  logic              step_req,
   input  logic              step_up,
   output logic              ready,
   output logic [GAIN_W-1:0] gain_code,
   output logic              pga_sclk,
   output logic              pga_sdata,
   output logic              pga_load,
   output logic              at_max,
   output logic              at_min,
   output logic              gain_done,
   output logic              req_dropped
);

   localparam int MAX_CODE = (1 << GAIN_W) - 1;
   localparam int RC_W     = $clog2(RAIL_LIMIT + 1);
   localparam int SC_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   agc_state_e        state, state_nxt;
   logic [SC_W-1:0]   settle_cnt;
   logic [RC_W-1:0]   rail_cnt;
   logic [RC_W-1:0]   rail_cnt_inc;
   logic [GAIN_W-1:0] code_nxt;
   logic              at_rail_dir;
   logic              accept;
   logic              rail_hit;
   logic              shift_busy;
   logic              shift_last;
   logic              shift_done;

   agc_pga_shifter #(
      .GAIN_W(GAIN_W)
   ) u_shifter (
      .clk        (clk),
      .RESETn     (RESETn),
      .start      (accept),
      .data       (code_nxt),
      .busy       (shift_busy),
      .shift_last (shift_last),
      .done       (shift_done),
      .pga_sclk   (pga_sclk),
      .pga_sdata  (pga_sdata),
      .pga_load   (pga_load)
   );

   // Request decode: a request pinned against its rail is counted instead of transacted.
   always_comb begin
      at_max       = (gain_code == GAIN_W'(MAX_CODE));
      at_min       = (gain_code == '0);
      ready        = (state == ST_IDLE) && !shift_busy;
      at_rail_dir  = step_up ? at_max : at_min;
      accept       = ready && enable && step_req && !at_rail_dir;
      rail_hit     = ready && enable && step_req && at_rail_dir;
      code_nxt     = GAIN_W'(sat_step(int'(gain_code), step_up, STEP, MAX_CODE));
      rail_cnt_inc = (rail_cnt == RC_W'(RAIL_LIMIT)) ? rail_cnt : rail_cnt + 1'b1;
   end

   // Next-state: a transaction always runs to completion once accepted.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (accept) state_nxt = ST_SHIFT;
         ST_SHIFT:  if (shift_last) state_nxt = ST_LOAD;
         ST_LOAD:   if (shift_done) state_nxt = ST_SETTLE;
         ST_SETTLE: if (settle_cnt == SC_W'(SETTLE_CYCLES - 1)) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // State register and settle window counter.
   always_ff @(posedge clk or negedge RESETn) begin
      if (!RESETn) begin
         state      <= ST_IDLE;
         settle_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_SETTLE) begin
            settle_cnt <= settle_cnt + 1'b1;
         end else begin
            settle_cnt <= '0;
         end
      end
   end

   // Committed gain code, rail tracking and sticky status flags.
   always_ff @(posedge clk or negedge RESETn) begin
      if (!RESETn) begin
         gain_code   <= GAIN_W'(GAIN_INIT);
         rail_cnt    <= '0;
         gain_done   <= 1'b0;
         req_dropped <= 1'b0;
      end else begin
         if (accept) begin
            gain_code <= code_nxt;
         end
         if (step_req && !ready) begin
            req_dropped <= 1'b1;
         end
         if (!enable) begin
            rail_cnt  <= '0;
            gain_done <= 1'b0;
         end else if (rail_hit) begin
            rail_cnt <= rail_cnt_inc;
            if (rail_cnt_inc == RC_W'(RAIL_LIMIT)) begin
               gain_done <= 1'b1;
            end
         end else if (accept) begin
            rail_cnt <= '0;
         end
      end
   end

endmodule
